// File: rtl/cache_ctrl.sv
// Sequencer between a CPU byte bus, a 128-byte direct-mapped cache and main memory.
// Reads look up the cache first; writes go through to memory and allocate into the cache.
module cache_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_wdata,
  output logic [7:0]       cpu_rdata,
  output logic             cpu_ready,
  output logic             cpu_err,
  output logic             busy,
  output logic [15:0]      cache_addr,
  output logic             cache_w_rd,
  output logic [7:0]       cache_wdata,
  input  logic [7:0]       cache_rdata,
  input  logic             cache_hit,
  output logic             mem_req,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, CHECK, MEM_RD, MEM_WR, FILL, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [15:0]      c_addr_q, c_addr_d;
  logic             c_wr_q, c_wr_d;
  logic [7:0]       c_wdata_q, c_wdata_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [15:0]      m_addr_q, m_addr_d;
  logic [7:0]       m_wdata_q, m_wdata_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      to_q      <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      c_addr_q  <= '0;
      c_wr_q    <= 1'b0;
      c_wdata_q <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      to_q      <= to_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      c_addr_q  <= c_addr_d;
      c_wr_q    <= c_wr_d;
      c_wdata_q <= c_wdata_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  // Outputs are registered on entry to the state that owns them, so each
  // state sees its own outputs for exactly the cycles it is resident.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    to_d      = to_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    c_addr_d  = c_addr_q;
    c_wr_d    = 1'b0;
    c_wdata_d = c_wdata_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (cpu_we) begin
            state_d   = MEM_WR;
            m_req_d   = 1'b1;
            m_we_d    = 1'b1;
            m_addr_d  = cpu_addr;
            m_wdata_d = cpu_wdata;
            to_d      = '0;
          end else begin
            state_d  = LOOKUP;
            c_addr_d = cpu_addr;
          end
        end
      end
      LOOKUP: state_d = CHECK;
      CHECK: begin
        if (cache_hit) begin
          rdata_d = cache_rdata;
          ready_d = 1'b1;
          hit_d   = sat_inc(hit_q);
          state_d = IDLE;
        end else begin
          miss_d   = sat_inc(miss_q);
          state_d  = MEM_RD;
          m_req_d  = 1'b1;
          m_we_d   = 1'b0;
          m_addr_d = addr_q;
          to_d     = '0;
        end
      end
      MEM_RD, MEM_WR: begin
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack) begin
          m_req_d   = 1'b0;
          c_wr_d    = 1'b1;
          c_addr_d  = addr_q;
          c_wdata_d = (state_q == MEM_RD) ? mem_rdata : wdata_q;
          state_d   = FILL;
        end else if ((TIMEOUT != 0) && (to_q == TO_W'(TO_LAST))) begin
          m_req_d = 1'b0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = 8'hFF;
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          to_d = to_q + 1'b1;
        end
      end
      FILL: state_d = DONE;
      DONE: begin
        // The fill data is still held on the cache write-data register.
        rdata_d = c_wdata_q;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign cpu_rdata   = rdata_q;
  assign cpu_ready   = ready_q;
  assign cpu_err     = err_q;
  assign busy        = busy_q;
  assign cache_addr  = c_addr_q;
  assign cache_w_rd  = c_wr_q;
  assign cache_wdata = c_wdata_q;
  assign mem_req     = m_req_q;
  assign mem_we      = m_we_q;
  assign mem_addr    = m_addr_q;
  assign mem_wdata   = m_wdata_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: acts as cache and memory, compares every access
// against a transaction-level model of latency, data, fills and statistics.
module tb_cache_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk_1;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [15:0]   cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic          busy;
  logic [15:0]   cache_addr;
  logic          cache_w_rd;
  logic [7:0]    cache_wdata;
  logic [7:0]    cache_rdata;
  logic          cache_hit;
  logic          mem_req;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          mem_ack;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int txn    = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  cache_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_1(clk_1), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err), .busy(busy),
    .cache_addr(cache_addr), .cache_w_rd(cache_w_rd), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (txn %0d): observed %0h expected %0h", tag, txn, obs, exp);
  endtask

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // One CPU access. d = mem_req cycle (1-based) on which memory acks.
  task automatic do_access(input bit we, input logic [15:0] a, input logic [7:0] wd,
                           input bit hit, input logic [7:0] crd, input int d,
                           input logic [7:0] md, input bit hold);
    int e_lat, e_mcyc, e_fills;
    logic [7:0] e_rd, e_fd;
    bit e_err, tmo;
    int lat, mcyc, fills;
    logic [7:0] o_rd, m_wd, f_d;
    logic o_err, m_we;
    logic [15:0] m_a, f_a;
    bit done, bad_busy, bad_err;

    txn++;
    tmo = (TO != 0) && (d > TO);
    e_fd = we ? wd : md;
    if (!we && hit) begin
      e_lat = 3; e_rd = crd; e_err = 1'b0; e_mcyc = 0; e_fills = 0;
      exp_hit = sat(exp_hit);
    end else begin
      if (!we) exp_miss = sat(exp_miss);
      e_mcyc  = tmo ? TO : d;
      e_fills = tmo ? 0 : 1;
      e_err   = tmo;
      e_rd    = tmo ? 8'hFF : e_fd;
      e_lat   = (we ? 1 : 3) + (tmo ? TO : d + 2);
    end

    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cache_hit = hit; cache_rdata = crd; mem_ack = 1'b0; mem_rdata = ~md;
    lat = 0; mcyc = 0; fills = 0; done = 0; bad_busy = 0; bad_err = 0;
    o_rd = 'x; o_err = 1'bx; m_a = 'x; m_we = 1'bx; m_wd = 'x; f_a = 'x; f_d = 'x;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk_1); #1;
      if (!hold) cpu_req = 1'b0;
      cpu_we = ~we; cpu_addr = ~a; cpu_wdata = ~wd;
      mem_ack = 1'b0; mem_rdata = ~md;
      if (cpu_err && !cpu_ready) bad_err = 1;
      if (mem_req) begin
        mcyc++; m_a = mem_addr; m_we = mem_we; m_wd = mem_wdata;
        if (mcyc == d) begin mem_ack = 1'b1; mem_rdata = md; end
      end
      if (cache_w_rd) begin fills++; f_a = cache_addr; f_d = cache_wdata; end
      if (cpu_ready) begin
        done = 1; lat = c; o_rd = cpu_rdata; o_err = cpu_err; cpu_req = 1'b0;
      end else if (!busy) bad_busy = 1;
    end

    check("ready_seen", 32'(done), 32'd1);
    if (done) begin
      check("latency", 32'(lat), 32'(e_lat));
      check("cpu_rdata", 32'(o_rd), 32'(e_rd));
      check("cpu_err", 32'(o_err), 32'(e_err));
    end
    check("mem_cycles", 32'(mcyc), 32'(e_mcyc));
    check("fill_count", 32'(fills), 32'(e_fills));
    check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    check("busy_while_active", 32'(bad_busy), 32'd0);
    check("err_without_ready", 32'(bad_err), 32'd0);
    if (e_mcyc > 0) begin
      check("mem_addr", 32'(m_a), 32'(a));
      check("mem_we", 32'(m_we), 32'(we));
      if (we) check("mem_wdata", 32'(m_wd), 32'(wd));
    end
    if (e_fills > 0) begin
      check("fill_addr", 32'(f_a), 32'(a));
      check("fill_data", 32'(f_d), 32'(e_fd));
    end

    @(posedge clk_1); #1;
    check("ready_one_cycle", 32'(cpu_ready), 32'd0);
    check("err_idle", 32'(cpu_err), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0; #2; rst = 1'b1;
    exp_hit = 0; exp_miss = 0;
  endtask

  initial begin
    logic [7:0] v;
    bit seen, bad;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cache_rdata = '0; cache_hit = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk_1);
    #1;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_err", 32'(cpu_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_cache_w_rd", 32'(cache_w_rd), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_cache_addr", 32'(cache_addr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    rst = 1'b1;
    @(posedge clk_1); #1;

    // Directed: miss, hit, write, timeouts, ack on the final cycle.
    do_access(1'b0, 16'h1234, 8'h00, 1'b0, 8'h11, 3, 8'h5A, 1'b0);
    do_access(1'b0, 16'h1234, 8'h00, 1'b1, 8'h5A, 1, 8'h77, 1'b0);
    do_access(1'b1, 16'h0080, 8'hC3, 1'b0, 8'h00, 2, 8'h99, 1'b0);
    do_access(1'b0, 16'h4321, 8'h00, 1'b0, 8'h00, 99, 8'h3C, 1'b0);
    do_access(1'b0, 16'h4321, 8'h00, 1'b0, 8'h00, TO, 8'h3C, 1'b0);
    do_access(1'b1, 16'hBEEF, 8'h66, 1'b0, 8'h00, 99, 8'h00, 1'b0);
    do_access(1'b1, 16'hBEEF, 8'h66, 1'b0, 8'h00, TO, 8'h00, 1'b1);

    // Reset while a read miss waits on memory.
    txn++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0ABC; cache_hit = 1'b0;
    @(posedge clk_1); #1;
    cpu_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk_1); #1;
      seen = mem_req;
    end
    check("reached_mem_rd", 32'(seen), 32'd1);
    rst = 1'b0; #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(cpu_ready), 32'd0);
    check("rst_mid_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_mid_miss_cnt", 32'(miss_cnt), 32'd0);
    exp_hit = 0; exp_miss = 0;
    @(posedge clk_1); #1;
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hE7;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_1); #1;
      mem_ack = 1'b0;
      if (cpu_ready || cache_w_rd || busy || mem_req) bad = 1;
    end
    check("lost_after_reset", 32'(bad), 32'd0);
    do_access(1'b0, 16'h0ABC, 8'h00, 1'b0, 8'h00, 2, 8'hA5, 1'b1);

    // Randomized accesses.
    for (int i = 0; i < 50; i++) begin
      v = 8'($urandom);
      do_access(($urandom_range(0, 2) == 0), 16'($urandom), v,
                1'($urandom), 8'($urandom), $urandom_range(1, TO + 2),
                8'($urandom), 1'($urandom));
    end

    // Hit counter saturation.
    @(posedge clk_1); #1;
    pulse_reset();
    for (int i = 0; i <= MAXC; i++)
      do_access(1'b0, 16'(i), 8'h00, 1'b1, 8'(i * 7), 1, 8'h00, 1'b0);
    check("hit_saturated", 32'(hit_cnt), 32'(MAXC));
    check("miss_after_sat", 32'(miss_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
